// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply/divide unit: radix-2 shift-add multiply or restoring
// divide over WIDTH cycles, with a registered result that holds between ops.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic               dbz_pend;
  // const_q holds the operand that stays fixed (multiplicand or divisor);
  // shift_q walks the other one (multiplier bits out, or dividend bits out / quotient bits in).
  logic [WIDTH-1:0]   const_q;
  logic [WIDTH-1:0]   shift_q;
  // Product accumulator for MUL/MULH; the low WIDTH+1 bits are the partial remainder for DIV/REM.
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   shift_nxt;
  logic [WIDTH-1:0]   res_sel;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_nxt   = acc;
    shift_nxt = shift_q;
    addend    = shift_q[0] ? const_q : '0;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    rem_shift = {acc[WIDTH-1:0], shift_q[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {2'b00, const_q};

    if (!op_q[1]) begin
      acc_nxt   = {mul_sum, acc[WIDTH-1:1]};
      shift_nxt = shift_q >> 1;
    end else begin
      acc_nxt          = '0;
      // A negative trial (borrow out) means restore the shifted remainder.
      acc_nxt[WIDTH:0] = trial[WIDTH+1] ? rem_shift : trial[WIDTH:0];
      shift_nxt        = {shift_q[WIDTH-2:0], ~trial[WIDTH+1]};
    end

    case (op_q)
      OP_MUL:  res_sel = acc_nxt[WIDTH-1:0];
      OP_MULH: res_sel = acc_nxt[2*WIDTH-1:WIDTH];
      OP_DIV:  res_sel = shift_nxt;
      default: res_sel = acc_nxt[WIDTH-1:0];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      op_q        <= OP_MUL;
      dbz_pend    <= 1'b0;
      const_q     <= '0;
      shift_q     <= '0;
      acc         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            count    <= '0;
            op_q     <= op;
            dbz_pend <= op[1] && (b == '0);
            const_q  <= op[1] ? b : a;
            shift_q  <= op[1] ? a : b;
            acc      <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc     <= acc_nxt;
          shift_q <= shift_nxt;
          count   <= count + CW'(1);
          if (count == LAST_ITER) begin
            state       <= DONE;
            result      <= res_sel;
            div_by_zero <= dbz_pend;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
